// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b (- bin).
// One full-subtractor cell processes one bit per clock, LSB first, with the
// borrow carried between bits in a flip-flop. Operands are latched on start
// and the result is published with a one-cycle done pulse.
// Optional feature macro: SERIAL_SUB_BORROW_IN_EN adds a borrow-in port 'bin'
// that seeds the borrow flip-flop when an operation is accepted.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic             bin,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    count;

  logic             ai;
  logic             bi;
  logic             d;
  logic             br_next;
  logic             last_bit;
  logic             init_borrow;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign init_borrow = bin;
`else
  assign init_borrow = 1'b0;
`endif

  // Full-subtractor cell on the current LSBs plus the stored borrow
  always_comb begin
    ai       = a_sr[0];
    bi       = b_sr[0];
    d        = ai ^ bi ^ br;
    br_next  = (~ai & bi) | (~(ai ^ bi) & br);
    last_bit = (count == LAST);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status outputs; start is only honoured in IDLE
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand/result shifting, borrow and bit counter; diff/bout update only on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= init_borrow;
            count <= '0;
          end
        end
        RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= {d, res_sr[WIDTH-1:1]};
          br     <= br_next;
          count  <= count + CW'(1);
          if (last_bit) begin
            diff <= {d, res_sr[WIDTH-1:1]};
            bout <= br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
